// File: rtl/axis_pattern_src.sv
// axis_pattern_src: byte-wide AXI4-Stream pattern source.
// Emits a programmed burst of counter or LFSR bytes on a start pulse,
// honours backpressure, and can insert idle gaps between beats.
// Optional feature macro: AXIS_PATTERN_SRC_LFSR_EN builds the LFSR
// generator and lets 'mode' select it; without it the source always counts.

module axis_pattern_src #(
    parameter int         LEN_WIDTH = 16,
    parameter logic [7:0] LFSR_SEED = 8'h01
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    input  logic                 mode,
    input  logic [3:0]           gap,
    output logic                 busy,
    output logic                 done,
    output logic [LEN_WIDTH-1:0] beat_cnt,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [7:0]           m_axis_tdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state_q;
    logic [LEN_WIDTH-1:0] remaining_q;
    logic [LEN_WIDTH-1:0] beatCnt_q;
    logic [3:0]           gapLen_q;
    logic [3:0]           gapCnt_q;
    logic [7:0]           data_q;
    logic                 tvalid_q;
    logic                 done_q;
    logic                 busy_q;
    logic [7:0]           nextData_d;
    logic [7:0]           firstData_d;
    logic                 handshake;

`ifdef AXIS_PATTERN_SRC_LFSR_EN
    logic                 mode_q;

    // Pick the first byte of a burst and the byte that follows a handshake,
    // using the counter or the x^8+x^6+x^5+x^4+1 LFSR depending on mode.
    always_comb begin
        firstData_d = mode ? LFSR_SEED : 8'h00;
        nextData_d  = data_q + 8'd1;
        if (mode_q) begin
            nextData_d = {data_q[6:0], data_q[7] ^ data_q[5] ^ data_q[4] ^ data_q[3]};
        end
    end
`else
    logic                 unusedModeAndSeed;

    // Counter-only build: mode and the seed have no effect on the stream.
    always_comb begin
        firstData_d = 8'h00;
        nextData_d  = data_q + 8'd1;
    end

    assign unusedModeAndSeed = mode ^ (^LFSR_SEED);
`endif

    assign handshake = tvalid_q & m_axis_tready;

    // Burst sequencer: all outputs are registered here so that tvalid and
    // tdata never depend combinationally on tready.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            beatCnt_q   <= '0;
            gapLen_q    <= 4'd0;
            gapCnt_q    <= 4'd0;
            data_q      <= 8'h00;
            tvalid_q    <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
`ifdef AXIS_PATTERN_SRC_LFSR_EN
            mode_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        remaining_q <= len;
                        beatCnt_q   <= '0;
                        gapLen_q    <= gap;
                        data_q      <= firstData_d;
                        busy_q      <= 1'b1;
`ifdef AXIS_PATTERN_SRC_LFSR_EN
                        mode_q      <= mode;
`endif
                        if (len != '0) begin
                            state_q  <= SEND;
                            tvalid_q <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (handshake) begin
                        beatCnt_q   <= beatCnt_q + 1'b1;
                        remaining_q <= remaining_q - 1'b1;
                        data_q      <= nextData_d;
                        if (remaining_q == {{(LEN_WIDTH-1){1'b0}}, 1'b1}) begin
                            state_q  <= DONE;
                            tvalid_q <= 1'b0;
                            done_q   <= 1'b1;
                        end else if (gapLen_q != 4'd0) begin
                            state_q  <= GAP;
                            tvalid_q <= 1'b0;
                            gapCnt_q <= gapLen_q;
                        end
                    end
                end
                GAP: begin
                    if (gapCnt_q == 4'd1) begin
                        state_q  <= SEND;
                        tvalid_q <= 1'b1;
                    end else begin
                        gapCnt_q <= gapCnt_q - 4'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    tvalid_q <= 1'b0;
                    done_q   <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign beat_cnt      = beatCnt_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = data_q;

endmodule

// File: tb/tb_axis_pattern_src.sv
// tb_axis_pattern_src: directed, table-driven bench for axis_pattern_src.
// Covers counter bursts, wrap, gaps, zero length, backpressure with
// ignored start pulses, reset mid-burst, and the LFSR sequence when
// AXIS_PATTERN_SRC_LFSR_EN is defined.

module tb_axis_pattern_src;

    localparam int LW = 16;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          start;
    logic [LW-1:0] len;
    logic          mode;
    logic [3:0]    gap;
    logic          busy;
    logic          done;
    logic [LW-1:0] beat_cnt;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [7:0]    m_axis_tdata;

    int errors = 0;
    int checks = 0;

    logic [7:0] beatQ[$];
    bit         validQ[$];
    int         stabErr;
    int         doneCycle;
    int         busyAtDone;
    int         cntAtDone;

    typedef struct {
        int         len;
        int         mode;
        int         gap;
        int         expDone;
        int         expBeats;
        logic [7:0] expFirst;
        logic [7:0] expLast;
    } vec_t;

    vec_t vecs[7];

    axis_pattern_src #(.LEN_WIDTH(LW), .LFSR_SEED(8'h01)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .start         (start),
        .len           (len),
        .mode          (mode),
        .gap           (gap),
        .busy          (busy),
        .done          (done),
        .beat_cnt      (beat_cnt),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata)
    );

    always #5 aclk = ~aclk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    // Run one burst. Inputs change 1 time unit after a rising edge, outputs are
    // sampled on the falling edge. Cycle 1 is the cycle after the start edge.
    task automatic applyStimulus(input int l, input int m, input int g,
                                 input bit randReady, input bit startWhileBusy);
        bit pending;
        logic [7:0] prevData;
        beatQ.delete();
        validQ.delete();
        stabErr    = 0;
        doneCycle  = -1;
        busyAtDone = 0;
        cntAtDone  = -1;
        pending    = 1'b0;
        prevData   = 8'h00;
        @(posedge aclk); #1;
        start = 1'b1; len = LW'(l); mode = m[0]; gap = 4'(g);
        m_axis_tready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge aclk); #1;
        if (startWhileBusy) begin
            len = LW'(7); mode = ~mode; gap = 4'd3;
        end else begin
            start = 1'b0;
        end
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            @(negedge aclk);
            validQ.push_back(m_axis_tvalid);
            if (pending && (!m_axis_tvalid || m_axis_tdata !== prevData)) stabErr++;
            pending  = m_axis_tvalid && !m_axis_tready;
            prevData = m_axis_tdata;
            if (m_axis_tvalid && m_axis_tready) beatQ.push_back(m_axis_tdata);
            if (done) begin
                doneCycle  = cyc;
                busyAtDone = busy;
                cntAtDone  = beat_cnt;
                break;
            end
            @(posedge aclk); #1;
            if (randReady) m_axis_tready = 1'($urandom_range(0, 1));
        end
        if (doneCycle < 0) begin
            checkOutput("burst_timeout", 0, 1);
        end
        @(posedge aclk); #1;
        start = 1'b0;
        m_axis_tready = 1'b1;
        @(negedge aclk);
        checkOutput("busy_after_done", busy, 0);
        checkOutput("done_one_cycle", done, 0);
        checkOutput("tvalid_after_done", m_axis_tvalid, 0);
    endtask

    initial begin
        vecs[0] = '{len: 4,   mode: 0, gap: 0, expDone: 5,   expBeats: 4,   expFirst: 8'h00, expLast: 8'h03};
        vecs[1] = '{len: 300, mode: 0, gap: 0, expDone: 301, expBeats: 300, expFirst: 8'h00, expLast: 8'h2B};
        vecs[2] = '{len: 3,   mode: 0, gap: 2, expDone: 8,   expBeats: 3,   expFirst: 8'h00, expLast: 8'h02};
        vecs[3] = '{len: 1,   mode: 0, gap: 5, expDone: 2,   expBeats: 1,   expFirst: 8'h00, expLast: 8'h00};
        vecs[4] = '{len: 0,   mode: 0, gap: 0, expDone: 1,   expBeats: 0,   expFirst: 8'h00, expLast: 8'h00};
`ifdef AXIS_PATTERN_SRC_LFSR_EN
        vecs[5] = '{len: 5,   mode: 1, gap: 0, expDone: 6,   expBeats: 5,   expFirst: 8'h01, expLast: 8'h11};
`else
        vecs[5] = '{len: 5,   mode: 1, gap: 0, expDone: 6,   expBeats: 5,   expFirst: 8'h00, expLast: 8'h04};
`endif
        vecs[6] = '{len: 2,   mode: 0, gap: 1, expDone: 4,   expBeats: 2,   expFirst: 8'h00, expLast: 8'h01};

        aresetn = 1'b0; start = 1'b0; len = '0; mode = 1'b0; gap = 4'd0; m_axis_tready = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_beat_cnt", beat_cnt, 0);
        checkOutput("reset_tvalid", m_axis_tvalid, 0);
        checkOutput("reset_tdata", m_axis_tdata, 0);
        @(posedge aclk); #1;
        aresetn = 1'b1;

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].len, vecs[i].mode, vecs[i].gap, 1'b0, 1'b0);
            checkOutput($sformatf("v%0d_done_cycle", i), doneCycle, vecs[i].expDone);
            checkOutput($sformatf("v%0d_beats", i), beatQ.size(), vecs[i].expBeats);
            checkOutput($sformatf("v%0d_beat_cnt", i), cntAtDone, vecs[i].expBeats);
            checkOutput($sformatf("v%0d_busy_at_done", i), busyAtDone, 1);
            if (vecs[i].expBeats > 0 && beatQ.size() > 0) begin
                checkOutput($sformatf("v%0d_first", i), beatQ[0], vecs[i].expFirst);
                checkOutput($sformatf("v%0d_last", i), beatQ[beatQ.size()-1], vecs[i].expLast);
            end
            if (i == 0) begin
                for (int k = 0; k < 4 && k < validQ.size(); k++)
                    checkOutput($sformatf("len4_tvalid_c%0d", k+1), validQ[k], 1);
                for (int k = 0; k < 4 && k < beatQ.size(); k++)
                    checkOutput($sformatf("len4_data%0d", k), beatQ[k], k);
            end
            if (i == 1 && beatQ.size() >= 257) begin
                checkOutput("wrap_beat256", beatQ[255], 8'hFF);
                checkOutput("wrap_beat257", beatQ[256], 8'h00);
            end
            if (i == 2) begin
                bit expV[7];
                expV = '{1, 0, 0, 1, 0, 0, 1};
                for (int k = 0; k < 7 && k < validQ.size(); k++)
                    checkOutput($sformatf("gap_tvalid_c%0d", k+1), validQ[k], expV[k]);
            end
            if (i == 4 && validQ.size() > 0) begin
                checkOutput("len0_no_tvalid", validQ[0], 0);
            end
`ifdef AXIS_PATTERN_SRC_LFSR_EN
            if (i == 5 && beatQ.size() == 5) begin
                logic [7:0] expL[5];
                expL = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
                for (int k = 0; k < 5; k++)
                    checkOutput($sformatf("lfsr_beat%0d", k), beatQ[k], expL[k]);
            end
`endif
        end

        // Random backpressure with start held high throughout the burst,
        // including across the DONE edge: only the first start may count.
        for (int rep = 0; rep < 3; rep++) begin
            applyStimulus(3, 0, 0, 1'b1, 1'b1);
            checkOutput($sformatf("bp%0d_stability", rep), stabErr, 0);
            checkOutput($sformatf("bp%0d_beats", rep), beatQ.size(), 3);
            checkOutput($sformatf("bp%0d_beat_cnt", rep), cntAtDone, 3);
            for (int k = 0; k < 3 && k < beatQ.size(); k++)
                checkOutput($sformatf("bp%0d_data%0d", rep, k), beatQ[k], k);
        end

        // Reset in the middle of a len=10 burst.
        @(posedge aclk); #1;
        start = 1'b1; len = LW'(10); mode = 1'b0; gap = 4'd0; m_axis_tready = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        checkOutput("midrst_tvalid", m_axis_tvalid, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_beat_cnt", beat_cnt, 0);
        checkOutput("midrst_tdata", m_axis_tdata, 0);
        #1;
        aresetn = 1'b1;
        begin
            int sawDone;
            int sawValid;
            sawDone  = 0;
            sawValid = 0;
            repeat (12) begin
                @(negedge aclk);
                if (done) sawDone = 1;
                if (m_axis_tvalid) sawValid = 1;
            end
            checkOutput("midrst_no_done", sawDone, 0);
            checkOutput("midrst_no_tvalid", sawValid, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
